// File: rtl/bomb_blast.sv
// Bomb countdown and explosion engine for the 10x10 arena.
// On every game tick it snapshots the maps, ages the bomb fuses, sends flames
// out of each bomb that reaches zero, and publishes the updated maps.
// The work is serialised: one cell or one flame step per clock.
module bomb_blast #(
  parameter int RANGE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [199:0] arena_in,
  input  logic [199:0] bomb_in,
  input  logic [3:0]   playerAx,
  input  logic [3:0]   playerAy,
  input  logic [3:0]   playerBx,
  input  logic [3:0]   playerBy,
  output logic [199:0] arena_out,
  output logic [199:0] bomb_out,
  output logic [99:0]  fire,
  output logic         playerA_hit,
  output logic         playerB_hit,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, BLAST, COMMIT} state_t;

  localparam logic [3:0] RANGE_L = 4'(RANGE);

  state_t state, state_next;

  logic [1:0]  snap_arena [100];
  logic [1:0]  snap_bomb  [100];
  logic [1:0]  live_arena [100];
  logic [1:0]  live_bomb  [100];
  logic [99:0] exploding, burn, brick_burned;
  logic [3:0]  cx, cy, cx_next, cy_next;
  logic [1:0]  dir;
  logic [3:0]  step;
  logic        stopped;
  logic [3:0]  pax, pay, pbx, pby;
  logic [6:0]  idx, tidx, pa_idx, pb_idx;
  logic signed [5:0] tx, ty;
  logic        off_map, blocker, ray_live, cell_end, last_cell;
  logic        pa_valid, pb_valid;
  logic [199:0] arena_next, bomb_next;

  genvar k;
  generate
    for (k = 0; k < 100; k++) begin : g_cell
      assign live_arena[k] = arena_in[2*k+1:2*k];
      assign live_bomb[k]  = bomb_in[2*k+1:2*k];
      // Only bricks that actually burned are removed from the live arena.
      assign arena_next[2*k+1:2*k] = brick_burned[k] ? 2'd0 : live_arena[k];
      // A bomb dropped into an empty cell during the pass must survive commit.
      assign bomb_next[2*k+1:2*k] = (snap_bomb[k] == 2'd0 && live_bomb[k] != 2'd0)
                                    ? live_bomb[k] : snap_bomb[k];
    end
  endgenerate

  assign idx      = 7'(cx) * 7'd10 + 7'(cy);
  assign pa_idx   = 7'(pax) * 7'd10 + 7'(pay);
  assign pb_idx   = 7'(pbx) * 7'd10 + 7'(pby);
  assign pa_valid = (pax <= 4'd9) && (pay <= 4'd9);
  assign pb_valid = (pbx <= 4'd9) && (pby <= 4'd9);

  // Row-major walk over the arena, wrapping back to cell 0 after cell 99.
  always_comb begin
    cy_next = cy + 4'd1;
    cx_next = cx;
    if (cy == 4'd9) begin
      cy_next = 4'd0;
      cx_next = (cx == 4'd9) ? 4'd0 : cx + 4'd1;
    end
  end

  // Flame target for the current direction/step; rows and columns never wrap.
  always_comb begin
    tx = $signed({2'b00, cx});
    ty = $signed({2'b00, cy});
    case (dir)
      2'd0:    tx = tx - $signed({2'b00, step});
      2'd1:    tx = tx + $signed({2'b00, step});
      2'd2:    ty = ty - $signed({2'b00, step});
      default: ty = ty + $signed({2'b00, step});
    endcase
    off_map   = (tx < 0) || (tx > 6'sd9) || (ty < 0) || (ty > 6'sd9);
    tidx      = 7'(tx[3:0]) * 7'd10 + 7'(ty[3:0]);
    blocker   = !off_map && ((snap_arena[tidx] == 2'd1) || snap_bomb[tidx][1]);
    ray_live  = (step == 4'd1) || !stopped;
    cell_end  = !exploding[idx] || (dir == 2'd3 && step == RANGE_L);
    last_cell = (idx == 7'd99) && cell_end;
  end

  // Next-state decode; ticks outside IDLE are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = LOAD;
      LOAD:    state_next = SCAN;
      SCAN:    if (idx == 7'd99) state_next = BLAST;
      BLAST:   if (last_cell) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Working copy of the maps, fuse ageing and flame propagation.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: begin
        snap_arena   <= live_arena;
        snap_bomb    <= live_bomb;
        exploding    <= '0;
        burn         <= '0;
        brick_burned <= '0;
        pax <= playerAx;
        pay <= playerAy;
        pbx <= playerBx;
        pby <= playerBy;
        cx <= 4'd0;
        cy <= 4'd0;
        dir <= 2'd0;
        step <= 4'd1;
        stopped <= 1'b0;
      end
      SCAN: begin
        case (snap_bomb[idx])
          2'd3: snap_bomb[idx] <= 2'd2;
          2'd2: snap_bomb[idx] <= 2'd1;
          2'd1: begin
            snap_bomb[idx] <= 2'd0;
            exploding[idx] <= 1'b1;
          end
          default: ;
        endcase
        cx <= cx_next;
        cy <= cy_next;
      end
      BLAST: begin
        if (!exploding[idx]) begin
          cx <= cx_next;
          cy <= cy_next;
        end else begin
          if (dir == 2'd0 && step == 4'd1) burn[idx] <= 1'b1;
          if (ray_live && !off_map) begin
            burn[tidx] <= 1'b1;
            if (snap_arena[tidx] == 2'd1) begin
              snap_arena[tidx]   <= 2'd0;
              brick_burned[tidx] <= 1'b1;
            end else if (snap_bomb[tidx][1]) begin
              // Chained bomb is primed for the next tick, not this pass.
              snap_bomb[tidx] <= 2'd1;
            end
          end
          stopped <= !ray_live || off_map || blocker;
          if (step == RANGE_L) begin
            step <= 4'd1;
            dir  <= dir + 2'd1;
            if (dir == 2'd3) begin
              cx <= cx_next;
              cy <= cy_next;
            end
          end else begin
            step <= step + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, updated only on the commit edge; hit flags are sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arena_out   <= '0;
      bomb_out    <= '0;
      fire        <= '0;
      playerA_hit <= 1'b0;
      playerB_hit <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == COMMIT);
      if (state == COMMIT) begin
        fire      <= burn;
        arena_out <= arena_next;
        bomb_out  <= bomb_next;
        if (pa_valid && burn[pa_idx]) playerA_hit <= 1'b1;
        if (pb_valid && burn[pb_idx]) playerB_hit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bomb_blast.sv
// Directed bench for bomb_blast with RANGE=2.
module tb_bomb_blast;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [199:0] arena_in, bomb_in;
  logic [3:0]   playerAx, playerAy, playerBx, playerBy;
  logic [199:0] arena_out, bomb_out;
  logic [99:0]  fire;
  logic         playerA_hit, playerB_hit, busy, done;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic b_first, b_done;

  bomb_blast #(.RANGE(2)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .arena_in(arena_in), .bomb_in(bomb_in),
    .playerAx(playerAx), .playerAy(playerAy),
    .playerBx(playerBx), .playerBy(playerBy),
    .arena_out(arena_out), .bomb_out(bomb_out), .fire(fire),
    .playerA_hit(playerA_hit), .playerB_hit(playerB_hit),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [199:0] put(input logic [199:0] v, input int c, input logic [1:0] val);
    logic [199:0] t;
    t = {198'd0, val};
    return v | (t << (2*c));
  endfunction

  function automatic logic [1:0] get(input logic [199:0] v, input int c);
    logic [199:0] t;
    t = v >> (2*c);
    return t[1:0];
  endfunction

  // One pass: tick sampled at edge E, observe #1 after each later edge E+n.
  // At n==chg bomb_in is replaced by live; at n==t2 a stray tick is raised.
  task automatic run_pass(input int chg, input logic [199:0] live, input int t2,
                          output int lat, output int ndone);
    lat = -1;
    ndone = 0;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int n = 1; n <= 320; n++) begin
      @(posedge clk);
      #1;
      if (n == chg) bomb_in = live;
      tick = (n == t2);
      if (n == 1) b_first = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          b_done = busy;
        end
      end
      if (lat > 0 && n >= lat + 20) break;
    end
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 1'b0;
    arena_in = '0; bomb_in = '0;
    playerAx = 4'd15; playerAy = 4'd15; playerBx = 4'd15; playerBy = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_checks++; if (arena_out !== '0) begin n_fail++; $display("FAIL reset_arena_out got %h want 0", arena_out); end
    n_checks++; if (bomb_out !== '0) begin n_fail++; $display("FAIL reset_bomb_out got %h want 0", bomb_out); end
    n_checks++; if (fire !== '0) begin n_fail++; $display("FAIL reset_fire got %h want 0", fire); end
    n_checks++; if ({playerA_hit, playerB_hit, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {playerA_hit, playerB_hit, busy, done});
    end
  endtask

  task automatic test_countdown;
    int lat, nd;
    logic [99:0] e;
    e = '0;
    e[35] = 1'b1; e[45] = 1'b1; e[55] = 1'b1; e[65] = 1'b1; e[75] = 1'b1;
    e[53] = 1'b1; e[54] = 1'b1; e[56] = 1'b1; e[57] = 1'b1;
    arena_in = '0;
    bomb_in = put('0, 55, 2'd3);
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 202) begin n_fail++; $display("FAIL cd1_latency got %0d want 202", lat); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL cd1_done_count got %0d want 1", nd); end
    n_checks++; if (b_first !== 1'b1) begin n_fail++; $display("FAIL cd1_busy_start got %b want 1", b_first); end
    n_checks++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL cd1_busy_at_done got %b want 0", b_done); end
    n_checks++; if (get(bomb_out, 55) !== 2'd2) begin n_fail++; $display("FAIL cd1_fuse got %0d want 2", get(bomb_out, 55)); end
    n_checks++; if (fire !== '0) begin n_fail++; $display("FAIL cd1_fire got %h want 0", fire); end
    bomb_in = put('0, 55, 2'd2);
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 202) begin n_fail++; $display("FAIL cd2_latency got %0d want 202", lat); end
    n_checks++; if (get(bomb_out, 55) !== 2'd1) begin n_fail++; $display("FAIL cd2_fuse got %0d want 1", get(bomb_out, 55)); end
    n_checks++; if (fire !== '0) begin n_fail++; $display("FAIL cd2_fire got %h want 0", fire); end
    bomb_in = put('0, 55, 2'd1);
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 209) begin n_fail++; $display("FAIL cd3_latency got %0d want 209", lat); end
    n_checks++; if (bomb_out !== '0) begin n_fail++; $display("FAIL cd3_bomb_out got %h want 0", bomb_out); end
    n_checks++; if (fire !== e) begin n_fail++; $display("FAIL cd3_fire got %h want %h", fire, e); end
  endtask

  task automatic test_brick;
    int lat, nd;
    logic [99:0] e;
    e = '0;
    e[35] = 1'b1; e[45] = 1'b1; e[55] = 1'b1; e[65] = 1'b1; e[75] = 1'b1;
    e[53] = 1'b1; e[54] = 1'b1; e[56] = 1'b1;
    arena_in = put('0, 56, 2'd1);
    bomb_in = put('0, 55, 2'd1);
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 209) begin n_fail++; $display("FAIL brick_latency got %0d want 209", lat); end
    n_checks++; if (fire !== e) begin n_fail++; $display("FAIL brick_fire got %h want %h", fire, e); end
    n_checks++; if (fire[57] !== 1'b0) begin n_fail++; $display("FAIL brick_beyond got %b want 0", fire[57]); end
    n_checks++; if (arena_out !== '0) begin n_fail++; $display("FAIL brick_cleared got %h want 0", arena_out); end
  endtask

  task automatic test_corner;
    int lat, nd;
    logic [99:0] e;
    e = '0;
    e[0] = 1'b1; e[1] = 1'b1; e[2] = 1'b1; e[10] = 1'b1; e[20] = 1'b1;
    arena_in = '0;
    bomb_in = put('0, 0, 2'd1);
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 209) begin n_fail++; $display("FAIL corner_latency got %0d want 209", lat); end
    n_checks++; if (fire !== e) begin n_fail++; $display("FAIL corner_fire got %h want %h", fire, e); end
    n_checks++; if ({fire[9], fire[90], fire[99]} !== 3'b000) begin
      n_fail++; $display("FAIL corner_wrap got %b want 000", {fire[9], fire[90], fire[99]});
    end
  endtask

  task automatic test_chain_hit;
    int lat, nd;
    logic [99:0] e;
    e = '0;
    e[35] = 1'b1; e[45] = 1'b1; e[55] = 1'b1; e[65] = 1'b1; e[75] = 1'b1;
    e[53] = 1'b1; e[54] = 1'b1; e[56] = 1'b1; e[57] = 1'b1;
    arena_in = put('0, 57, 2'd2);
    bomb_in = put(put('0, 55, 2'd1), 57, 2'd3);
    playerAx = 4'd5; playerAy = 4'd7;
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 209) begin n_fail++; $display("FAIL chain_latency got %0d want 209", lat); end
    n_checks++; if (get(bomb_out, 57) !== 2'd1) begin n_fail++; $display("FAIL chain_primed got %0d want 1", get(bomb_out, 57)); end
    n_checks++; if (playerA_hit !== 1'b1) begin n_fail++; $display("FAIL chain_hitA got %b want 1", playerA_hit); end
    n_checks++; if (playerB_hit !== 1'b0) begin n_fail++; $display("FAIL chain_hitB got %b want 0", playerB_hit); end
    n_checks++; if (fire !== e) begin n_fail++; $display("FAIL chain_fire got %h want %h", fire, e); end
    n_checks++; if (get(arena_out, 57) !== 2'd2) begin n_fail++; $display("FAIL chain_player_cell got %0d want 2", get(arena_out, 57)); end
    e = '0;
    e[37] = 1'b1; e[47] = 1'b1; e[57] = 1'b1; e[67] = 1'b1; e[77] = 1'b1;
    e[55] = 1'b1; e[56] = 1'b1; e[58] = 1'b1; e[59] = 1'b1;
    bomb_in = put('0, 57, 2'd1);
    run_pass(1, '0, 0, lat, nd);
    n_checks++; if (lat !== 209) begin n_fail++; $display("FAIL chain2_latency got %0d want 209", lat); end
    n_checks++; if (fire !== e) begin n_fail++; $display("FAIL chain2_fire got %h want %h", fire, e); end
    n_checks++; if (bomb_out !== '0) begin n_fail++; $display("FAIL chain2_bomb_out got %h want 0", bomb_out); end
  endtask

  task automatic test_mid_pass;
    int lat, nd;
    arena_in = '0;
    bomb_in = '0;
    playerAx = 4'd15; playerAy = 4'd15;
    run_pass(100, put('0, 12, 2'd3), 50, lat, nd);
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL mid_done_count got %0d want 1", nd); end
    n_checks++; if (lat !== 202) begin n_fail++; $display("FAIL mid_latency got %0d want 202", lat); end
    n_checks++; if (get(bomb_out, 12) !== 2'd3) begin n_fail++; $display("FAIL mid_new_bomb got %0d want 3", get(bomb_out, 12)); end
    n_checks++; if (fire !== '0) begin n_fail++; $display("FAIL mid_fire got %h want 0", fire); end
    n_checks++; if (playerA_hit !== 1'b1) begin n_fail++; $display("FAIL mid_hit_sticky got %b want 1", playerA_hit); end
  endtask

  task automatic test_reset_mid;
    int nd;
    bomb_in = put('0, 0, 2'd1);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bomb_out !== '0) begin n_fail++; $display("FAIL rst_mid_bomb_out got %h want 0", bomb_out); end
    n_checks++; if (fire !== '0) begin n_fail++; $display("FAIL rst_mid_fire got %h want 0", fire); end
    n_checks++; if ({playerA_hit, playerB_hit, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_flags got %b want 0000", {playerA_hit, playerB_hit, busy, done});
    end
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (250) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", nd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got %b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_countdown;
    test_brick;
    test_corner;
    test_chain_hit;
    test_mid_pass;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_blast.md
# bomb_blast

Bomb countdown and explosion engine for the 10x10 arena. It sits directly downstream of character control: it consumes the flattened arena and bomb maps, ages every bomb once per game tick and propagates flames. It then clears bricks, flags hit players, and returns the updated maps, which close the loop into character control's arena/bomb inputs. Work is serialised by a scan FSM, one cell or one flame step per clock.

## Interface
- RANGE, 2: flame reach in cells per direction (1..9).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle game-time pulse; starts one pass.
- arena_in  in  200  arena map; cell k=x*10+y at [2k+1:2k]; 0 empty, 1 brick, 2 player A, 3 player B.
- bomb_in  in  200  bomb map, same packing; 0 none, 3/2/1 fuse remaining.
- playerAx, playerAy, playerBx, playerBy  in  4 each  player row/column.
- arena_out  out  200  arena after the pass.
- bomb_out  out  200  bomb map after the pass.
- fire  out  100  cells burned in the last pass.
- playerA_hit, playerB_hit  out  1  sticky hit flags.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when new outputs appear.

## Operation
- States: IDLE, LOAD, SCAN, BLAST, COMMIT.
- IDLE: a tick moves to LOAD. Ticks in any other state are ignored and are not queued.
- LOAD, 1 cycle: snapshot arena_in, bomb_in and the four player coordinates. Clear the internal exploding[100] and burn[100] vectors.
- SCAN, 100 cycles, idx 0..99 ascending:
  - bomb 3→2, 2→1, 0 unchanged.
  - bomb 1→0 and set exploding[idx].
- BLAST, idx 0..99:
  - A non-exploding cell costs exactly 1 cycle.
  - An exploding cell costs exactly 4*RANGE cycles, in direction order up, down, left, right, steps 1..RANGE. Its own cell is burned on the first cycle.
  - Every step cycle is consumed even after a ray stops.
- Per flame step, on the target cell:
  - Off-map (row or column outside 0..9): ray stops. There is no wrap-around between row ends or columns.
  - Brick: burn, set snapshot arena to 0, ray stops.
  - Bomb 2 or 3: set to 1 (detonates on the next tick), burn, ray stops.
  - Empty cell or player: burn, continue.
  - A cell already exploding or burned: burn, continue.
- Chained bombs never explode within the same pass.
- COMMIT, 1 cycle:
  - fire ← burn.
  - arena_out ← live arena_in, with cells whose brick burned forced to 0.
  - bomb_out ← snapshot result, except cells where the snapshot was 0 and live bomb_in is non-zero take the live value. This preserves bombs placed mid-pass.
  - playerA_hit set if coordinates latched at LOAD are in range and burn[x*10+y]=1. playerB_hit likewise.
  - Return to IDLE.
- Hit flags clear only on rst.

## Timing
- Reset values: arena_out 0, bomb_out 0, fire 0, playerA_hit 0, playerB_hit 0, busy 0, done 0, state IDLE.
- rst mid-pass aborts the pass. Outputs return to their reset values and no done pulse is produced.
- Edge counting, for a tick sampled in IDLE at edge E:
  - LOAD is active after E.
  - SCAN spans edges E+2..E+101.
  - BLAST starts at E+102.
- With no explosions, the COMMIT edge is E+202, and new outputs plus done are visible after that edge.
- Each exploding cell adds 4*RANGE−1 cycles to the pass.
- busy is high from after E until the COMMIT edge, and low in the cycle done is high.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Outputs hold their values between COMMIT edges.

## Test plan
- Reset: assert rst asynchronously mid-SCAN → all outputs 0 immediately; no done pulse follows.
- Countdown and blast, RANGE=2, bomb 3 at cell 55, empty map:
  - Ticks 1 and 2 → bomb_out cell 55 reads 2, then 1; fire all 0.
  - Tick 3 → bomb_out all 0; fire exactly {35,45,55,65,75,53,54,56,57}.
  - Each of these passes sees done at E+202 for a single non-exploding cell and E+209 when the bomb explodes.
- Brick stop: bomb 1 at 55, brick at 56 → fire contains 56 but not 57; arena_out cell 56 = 0.
- Corner, no wrap: bomb 1 at cell 0 → fire exactly {0,1,2,10,20}; cells 9, 90 and 99 unburned.
- Chain and hit: bomb 1 at 55, bomb 3 at 57, player A at (5,7) → after the pass bomb_out cell 57 = 1 and playerA_hit=1. The next tick explodes 57.
- Mid-pass events:
  - A second tick at E+50 is ignored; exactly one done pulse is produced.
  - Bomb 3 written to cell 12 of bomb_in at E+100 → bomb_out cell 12 = 3 after COMMIT.
